vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Parametrised VGA timing and pixel-pipeline controller that sits between the game's pixel source and the VGA pins. It generates coordinates and sync/blanking for any mode set by parameters, with configurable sync polarity. It delays sync/blank by a configurable source latency so that registered (ROM/BRAM) pixel sources stay aligned. It also provides built-in test patterns and frame/line strobes.

## Interface
- H_DISPLAY, 800, active pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porches and sync width
- V_DISPLAY, 600, active lines
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porches and sync width
- HSYNC_POL / VSYNC_POL, 0 / 0, active sync level (0 = active-low)
- PIPE_DEPTH, 1, pixel-source latency in cycles, legal 1..8
- COLOR_W, 4, bits per colour channel
- clk  in  1  pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- mode  in  2  0 pass-through, 1 colour bars, 2 grid, 3 forced black
- pixel_x  out  11  requested X; all-ones outside active area
- pixel_y  out  11  requested Y; all-ones outside active area
- pixel_valid  out  1  pixel_x/pixel_y inside active area
- input_r / input_g / input_b  in  COLOR_W each  source colour for requested pixel
- hsync / vsync  out  1  sync outputs at parameter polarity
- de  out  1  data enable, high for active pixels at the output
- red / green / blue  out  COLOR_W each  output colour
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)
- line_start  out  1  one-cycle pulse coincident with output pixel (0,y) for every active y

## Operation
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP and V_TOTAL = sum of the vertical terms.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h wraps to 0, incrementing v. v wraps to 0 after V_TOTAL-1.
- Request stage (registered): for counter position (h,v), pixel_x=h and pixel_y=v with pixel_valid=1 if h<H_DISPLAY and v<V_DISPLAY. Otherwise both are 0x7FF and pixel_valid=0.
- Per position, the following are computed and carried through a PIPE_DEPTH-stage delay line:
  - active flag
  - hsync (h in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC))
  - vsync (v in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC))
  - frame/line flags
  - the internally generated pattern colour
- Output stage:
  - de = delayed active flag.
  - Sync outputs are the delayed sync flags XOR ~POL.
  - Colour is 0 when de=0. Otherwise the source is selected by the active mode:
    - Mode 0: input_r/g/b.
    - Mode 1: 8 bars of width BW=H_DISPLAY/8 (integer), bar index i=min(x/BW,7). Colour bits (R,G,B)=bits 2,1,0 of (7-i), each set bit driving the channel to all-ones (white, yellow, magenta, red, cyan, green, blue, black).
    - Mode 2: white if x%16==0, y%16==0, x==H_DISPLAY-1 or y==V_DISPLAY-1; else black.
    - Mode 3: black.
- mode is sampled into the active-mode register only when counters are at (0,0). A change mid-frame takes effect from the next frame's first pixel; no tearing.
- Reset (asynchronous, any time, including mid-line):
  - Counters, pipeline and active mode are cleared to 0.
  - pixel_x/pixel_y = 0x7FF and pixel_valid=0.
  - hsync/vsync take their inactive level (~POL).
  - de=0, red/green/blue=0, frame_start=0, line_start=0.

## Timing
- The first edge after reset release loads pixel_x=0, pixel_y=0, pixel_valid=1.
- If edge e updates pixel_x/pixel_y to P, the source must present P's colour stably before edge e+PIPE_DEPTH.
- At edge e+PIPE_DEPTH, red/green/blue, de, hsync, vsync, frame_start and line_start for P all update together.
- PIPE_DEPTH=1 suits a combinational source; PIPE_DEPTH=2 suits a one-cycle registered ROM.
- Output latency from coordinate to pin is exactly PIPE_DEPTH cycles. Coordinates advance one pixel per cycle with no stalls.
- Frame period is H_TOTAL*V_TOTAL cycles (663168 at defaults). hsync pulse is H_SYNC cycles; vsync pulse is V_SYNC*H_TOTAL cycles.
- The first frame_start occurs PIPE_DEPTH cycles after the first pixel_valid, and then every frame period.

## Test plan
- Reset: hold reset_n=0 mid-line at defaults. Required: hsync=vsync=1, de=0, rgb=0, pixel_x=pixel_y=0x7FF, no pulses. After release, frame_start fires exactly PIPE_DEPTH cycles after pixel_x=0.
- Alignment: PIPE_DEPTH=2, registered-ROM model returning red=pixel_x[3:0]. Required: every de-high cycle has red equal to the output pixel index mod 16, and de falls after exactly 800 cycles per line.
- Sync geometry at defaults: hsync low for 128 cycles starting 840 output cycles after line_start; vsync low for 4*1056 cycles starting at line 601; frame period 663168. Rerun with HSYNC_POL=VSYNC_POL=1: same pulses, high-true.
- Colour bars (mode=1): output x=99 → rgb=F/F/F, x=100 → F/F/0, x=700 → 0/0/0. All blanked cycles read 0.
- Mode switch: change mode 0→3 at line 300. Required: the rest of the frame still passes input colour; black begins exactly at the next frame_start.
- Grid (mode=2): pixels (0,5), (16,7), (799,3), (5,599) are white; pixel (5,5) is black.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with a configurable pixel-source latency, built-in test patterns
// and frame/line strobes, so that registered pixel sources stay aligned with sync and blanking.
module vga_timing_ctrl #(
    parameter int H_DISPLAY  = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_DISPLAY  = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DEPTH = 1,
    parameter int COLOR_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    output logic [10:0]        pixel_x,
    output logic [10:0]        pixel_y,
    output logic               pixel_valid,
    input  logic [COLOR_W-1:0] input_r,
    input  logic [COLOR_W-1:0] input_g,
    input  logic [COLOR_W-1:0] input_b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_DISPLAY / 8;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_DISPLAY);
    localparam logic [10:0] V_ACT    = 11'(V_DISPLAY);
    localparam logic [10:0] X_LAST   = 11'(H_DISPLAY - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_DISPLAY - 1);
    localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       frame;
        logic       line;
        logic [1:0] sel;
        logic [2:0] pat;
    } stage_t;

    logic [10:0] h_cnt, v_cnt, bar_pos;
    logic [2:0]  bar_idx;
    logic [1:0]  active_mode;
    logic        at_origin, in_active, grid_hit;
    logic [1:0]  pos_mode;
    stage_t      cur, tail;
    stage_t      pipe [PIPE_DEPTH];
    logic [COLOR_W-1:0] col_r, col_g, col_b;

    // The mode is latched at the origin, so the origin pixel itself must already see the new mode.
    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        pos_mode  = at_origin ? mode : active_mode;
        grid_hit  = (h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0) ||
                    (h_cnt == X_LAST) || (v_cnt == Y_LAST);
        cur        = '0;
        cur.active = in_active;
        cur.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        cur.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        cur.frame  = at_origin;
        cur.line   = (h_cnt == '0) && (v_cnt < V_ACT);
        cur.sel    = pos_mode;
        if (pos_mode == 2'd1)
            cur.pat = ~bar_idx;
        else if (pos_mode == 2'd2 && grid_hit)
            cur.pat = 3'b111;
        else
            cur.pat = 3'b000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_pos     <= '0;
            bar_idx     <= '0;
            active_mode <= '0;
        end else begin
            if (at_origin)
                active_mode <= mode;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
            // Bar index tracked incrementally; it saturates at 7 when H_DISPLAY is not a multiple of 8.
            if (h_cnt == H_LAST) begin
                bar_pos <= '0;
                bar_idx <= '0;
            end else if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x     <= 11'h7FF;
            pixel_y     <= 11'h7FF;
            pixel_valid <= 1'b0;
        end else if (in_active) begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            pixel_valid <= 1'b1;
        end else begin
            pixel_x     <= 11'h7FF;
            pixel_y     <= 11'h7FF;
            pixel_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < PIPE_DEPTH; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        tail  = pipe[PIPE_DEPTH-1];
        col_r = '0;
        col_g = '0;
        col_b = '0;
        if (tail.active) begin
            case (tail.sel)
                2'd0: begin
                    col_r = input_r;
                    col_g = input_g;
                    col_b = input_b;
                end
                2'd1, 2'd2: begin
                    col_r = {COLOR_W{tail.pat[2]}};
                    col_g = {COLOR_W{tail.pat[1]}};
                    col_b = {COLOR_W{tail.pat[0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= tail.hs ^ ~HSYNC_POL;
            vsync       <= tail.vs ^ ~VSYNC_POL;
            de          <= tail.active;
            red         <= col_r;
            green       <= col_g;
            blue        <= col_b;
            frame_start <= tail.frame;
            line_start  <= tail.line;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomised bench for vga_timing_ctrl: two small-mode instances (registered source with depth 2,
// combinational source with depth 1 and high-true syncs) compared every cycle against a frame model.
module tb_vga_timing_ctrl;

    localparam int HD = 64, HFP = 4, HSW = 8, HBP = 6;
    localparam int VD = 40, VFP = 1, VSW = 3, VBP = 4;
    localparam int HT = HD + HFP + HSW + HBP;
    localparam int VT = VD + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW = HD / 8;
    localparam int DA = 2;
    localparam int DB = 1;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mode;
    logic [11:0] salt;

    logic [10:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
    logic        pixel_valid_a, pixel_valid_b;
    logic [3:0]  in_r_a, in_g_a, in_b_a, in_r_b, in_g_b, in_b_b;
    logic        hsync_a, vsync_a, de_a, fs_a, ls_a;
    logic        hsync_b, vsync_b, de_b, fs_b, ls_b;
    logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [11:0] rom_a;

    int          edges;
    bit          in_reset;
    int          check_count;
    int          pass_count;
    logic [1:0]  frame_mode [$];

    vga_timing_ctrl #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DEPTH(DA), .COLOR_W(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .pixel_valid(pixel_valid_a),
        .input_r(in_r_a), .input_g(in_g_a), .input_b(in_b_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_ctrl #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DEPTH(DB), .COLOR_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .pixel_valid(pixel_valid_b),
        .input_r(in_r_b), .input_g(in_g_b), .input_b(in_b_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    function automatic logic [11:0] src_a(input logic [10:0] x, input logic [10:0] y, input logic [11:0] s);
        return {x[3:0], y[3:0] ^ s[3:0], x[7:4] ^ s[7:4]};
    endfunction

    function automatic logic [11:0] src_b(input logic [10:0] x, input logic [10:0] y, input logic [11:0] s);
        return {y[3:0], x[3:0] ^ s[11:8], x[3:0] + y[3:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source A behaves like a one-cycle registered ROM, source B is purely combinational.
    always @(posedge clk) rom_a <= src_a(pixel_x_a, pixel_y_a, salt);
    assign {in_r_a, in_g_a, in_b_a} = rom_a;
    always_comb {in_r_b, in_g_b, in_b_b} = src_b(pixel_x_b, pixel_y_b, salt);

    function automatic logic [22:0] exp_req(input int n);
        int h, v;
        if (n < 0) return {1'b0, 11'h7FF, 11'h7FF};
        h = n % HT;
        v = (n / HT) % VT;
        if (h < HD && v < VD) return {1'b1, 11'(h), 11'(v)};
        return {1'b0, 11'h7FF, 11'h7FF};
    endfunction

    // Expected pins for position index n: {hsync, vsync, de, frame_start, line_start, r, g, b}.
    function automatic logic [16:0] exp_out(input int n, input bit pol, input bit use_b);
        int h, v, bar, c;
        logic act, hs_on, vs_on, fs, ls;
        logic [1:0] m;
        logic [11:0] rgb;
        if (n < 0) return {~pol, ~pol, 15'd0};
        h = n % HT;
        v = (n / HT) % VT;
        m = frame_mode[n / FRAME];
        act   = (h < HD) && (v < VD);
        hs_on = (h >= HD + HFP) && (h < HD + HFP + HSW);
        vs_on = (v >= VD + VFP) && (v < VD + VFP + VSW);
        fs    = (h == 0) && (v == 0);
        ls    = (h == 0) && (v < VD);
        rgb   = 12'h000;
        if (act) begin
            case (m)
                2'd0: rgb = use_b ? src_b(11'(h), 11'(v), salt) : src_a(11'(h), 11'(v), salt);
                2'd1: begin
                    bar = h / BW;
                    if (bar > 7) bar = 7;
                    c = 7 - bar;
                    rgb = {((c & 4) != 0) ? 4'hF : 4'h0,
                           ((c & 2) != 0) ? 4'hF : 4'h0,
                           ((c & 1) != 0) ? 4'hF : 4'h0};
                end
                2'd2: if (h % 16 == 0 || v % 16 == 0 || h == HD - 1 || v == VD - 1) rgb = 12'hFFF;
                default: rgb = 12'h000;
            endcase
        end
        return {hs_on ? pol : ~pol, vs_on ? pol : ~pol, act, fs, ls, rgb};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, edges, actual, expected);
    endtask

    task automatic check_cycle();
        int nreq, na, nb;
        nreq = in_reset ? -1 : edges - 1;
        na   = in_reset ? -1 : edges - 1 - DA;
        nb   = in_reset ? -1 : edges - 1 - DB;
        check_output("req_a", 32'(exp_req(nreq)), 32'({pixel_valid_a, pixel_x_a, pixel_y_a}));
        check_output("out_a", 32'(exp_out(na, 1'b0, 1'b0)),
                     32'({hsync_a, vsync_a, de_a, fs_a, ls_a, red_a, green_a, blue_a}));
        check_output("req_b", 32'(exp_req(nreq)), 32'({pixel_valid_b, pixel_x_b, pixel_y_b}));
        check_output("out_b", 32'(exp_out(nb, 1'b1, 1'b1)),
                     32'({hsync_b, vsync_b, de_b, fs_b, ls_b, red_b, green_b, blue_b}));
    endtask

    // Called at a falling edge: drive mode, clock once, check at the next falling edge.
    task automatic apply_stimulus(input logic [1:0] new_mode);
        mode = new_mode;
        if (edges % FRAME == 0) frame_mode.push_back(mode);
        @(posedge clk);
        edges++;
        @(negedge clk);
        check_cycle();
    endtask

    // Reset is asserted between edges and checked before the next edge to prove it is asynchronous.
    task automatic do_reset(input int hold);
        #2;
        reset_n  = 1'b0;
        in_reset = 1'b1;
        #1;
        check_cycle();
        repeat (hold) begin
            @(negedge clk);
            check_cycle();
        end
        reset_n  = 1'b1;
        in_reset = 1'b0;
        edges    = 0;
        frame_mode.delete();
    endtask

    initial begin
        logic [1:0] cur_mode;
        logic [1:0] plan [4];
        check_count = 0;
        pass_count  = 0;
        edges       = 0;
        in_reset    = 1'b1;
        reset_n     = 1'b0;
        mode        = 2'd0;
        salt        = 12'($urandom);
        plan[0] = 2'd1; plan[1] = 2'd2; plan[2] = 2'd0; plan[3] = 2'd3;

        @(negedge clk);
        do_reset(3);

        cur_mode = 2'd0;
        for (int c = 0; c < 3 * FRAME + 500; c++) begin
            if ($urandom_range(0, 399) == 0) cur_mode = 2'($urandom_range(0, 3));
            apply_stimulus(cur_mode);
        end

        do_reset(4);

        // Each frame gets a planned mode at its origin; mid-frame noise must never show up.
        for (int c = 0; c < 4 * FRAME + 2 * HT; c++) begin
            if (c % FRAME == 0)
                cur_mode = plan[(c / FRAME) % 4];
            else if (c == 2 * FRAME + (VD / 2) * HT)
                cur_mode = 2'd3;
            else if ($urandom_range(0, 299) == 0)
                cur_mode = 2'($urandom_range(0, 3));
            apply_stimulus(cur_mode);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
